// File: rtl/fifo_read_stream_pkg.sv
// Shared types for the FIFO read-side streaming adapter: skid occupancy states and depth.
package fifo_pkg;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } occ_state_e;
endpackage

// File: rtl/fifo_read_stream_if.sv
// FIFO read port plus downstream valid/ready stream, seen from the adapter (master) or its environment (slave).
interface fifo_read_stream_if #(parameter int WIDTH = 8);
  logic             EMPTY;
  logic [WIDTH-1:0] R_DO;
  logic             REN;
  logic [WIDTH-1:0] M_DATA;
  logic             M_VALID;
  logic             M_READY;
  logic [1:0]       OCC;

  modport master (
    input  EMPTY, R_DO, M_READY,
    output REN, M_DATA, M_VALID, OCC
  );

  modport slave (
    output EMPTY, R_DO, M_READY,
    input  REN, M_DATA, M_VALID, OCC
  );
endinterface

// File: rtl/fifo_read_stream_skid2.sv
// Two-entry output buffer: captures FIFO read data, presents the oldest word downstream.
// Occupancy lives in the state register; M_DATA/M_VALID come straight from registers.
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cap_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  output logic [1:0]       occ_o,
  output logic             pop_o
);

  occ_state_e       state_q;
  logic [WIDTH-1:0] ent_q [SKID_DEPTH];

  assign m_valid_o = (state_q != S0);
  assign m_data_o  = ent_q[0];
  assign occ_o     = state_q;
  assign pop_o     = m_valid_o & m_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      case (state_q)
        S0: begin
          if (cap_i) begin
            ent_q[0] <= dat_i;
            state_q  <= S1;
          end
        end
        S1: begin
          if (cap_i && pop_o) begin
            ent_q[0] <= dat_i;
          end else if (cap_i) begin
            ent_q[1] <= dat_i;
            state_q  <= S2;
          end else if (pop_o) begin
            ent_q[0] <= ent_q[1];
            state_q  <= S0;
          end
        end
        S2: begin
          // A capture here only ever coincides with a pop; credit limiting keeps it so.
          if (pop_o) begin
            ent_q[0] <= ent_q[1];
            if (cap_i) begin
              ent_q[1] <= dat_i;
            end else begin
              state_q <= S1;
            end
          end
        end
        default: state_q <= S0;
      endcase
    end
  end

endmodule

// File: rtl/fifo_read_stream.sv
// Read-side adapter from a FIFO (REN/R_DO/EMPTY) to a valid/ready stream.
// REN is issued only while buffered plus in-flight words, less this cycle's pop, leave a free entry.
module fifo_read_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               RCLK,
  input  logic               RRST,
  fifo_read_stream_if.master bus
);

  logic       inflight_q;
  logic       inflight_d;
  logic       ren;
  logic       pop;
  logic [2:0] credit;

  fifo_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk_i     (RCLK),
    .rst_i     (RRST),
    .cap_i     (inflight_q),
    .dat_i     (bus.R_DO),
    .m_ready_i (bus.M_READY),
    .m_data_o  (bus.M_DATA),
    .m_valid_o (bus.M_VALID),
    .occ_o     (bus.OCC),
    .pop_o     (pop)
  );

  // pop implies OCC >= 1, so the subtraction cannot wrap.
  assign credit     = {1'b0, bus.OCC} + {2'b00, inflight_q} - {2'b00, pop};
  assign ren        = !RRST && !bus.EMPTY && (credit < 3'(SKID_DEPTH));
  assign inflight_d = ren;
  assign bus.REN    = ren;

  always_ff @(posedge RCLK or posedge RRST) begin
    if (RRST) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: behavioural FIFO model, scoreboard of written words, per-cycle vector table.
module tb_fifo_read_stream;
  localparam int W = 8;

  typedef struct {
    logic         rdy;
    logic         ren;
    logic         vld;
    logic [W-1:0] dat;
    logic [1:0]   occ;
  } vec_t;

  logic RCLK = 1'b0;
  logic RRST = 1'b1;
  logic rdy = 1'b0;
  logic empty_r = 1'b1;
  logic [W-1:0] rdo_r = '0;

  fifo_read_stream_if #(.WIDTH(W)) bus ();

  assign bus.EMPTY   = empty_r;
  assign bus.R_DO    = rdo_r;
  assign bus.M_READY = rdy;

  fifo_read_stream #(.WIDTH(W)) dut (
    .RCLK (RCLK),
    .RRST (RRST),
    .bus  (bus)
  );

  always #5 RCLK = ~RCLK;

  logic [W-1:0] fq [$];
  logic [W-1:0] sb [$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_read = 0;
  int n_deliv = 0;
  logic ren_seen = 1'b0;
  logic prev_vld = 1'b0;
  logic prev_pop = 1'b0;
  logic [W-1:0] prev_dat = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // FIFO model: a word read at an edge appears on R_DO just after that edge.
  always @(posedge RCLK) begin
    #1;
    if (ren_seen) begin
      chk("ren_has_word", 32'(fq.size() != 0), 1);
      if (fq.size() != 0) begin
        rdo_r = fq.pop_front();
        n_read++;
      end
    end
    empty_r = (fq.size() == 0);
  end

  // Monitor: invariants, hold-until-pop, and in-order delivery against the scoreboard.
  always @(negedge RCLK) begin
    ren_seen = bus.REN;
    if (!RRST) begin
      chk("ren_and_empty", 32'(bus.REN & bus.EMPTY), 0);
      chk("occ_le_2", 32'(bus.OCC <= 2'd2), 1);
      chk("vld_eq_occ_nz", 32'(bus.M_VALID), 32'(bus.OCC != 2'd0));
      if (prev_vld && !prev_pop) begin
        chk("hold_vld", 32'(bus.M_VALID), 1);
        chk("hold_dat", 32'(bus.M_DATA), 32'(prev_dat));
      end
      if (bus.M_VALID && bus.M_READY) begin
        chk("sb_has_word", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("order", 32'(bus.M_DATA), 32'(sb.pop_front()));
        n_deliv++;
      end
      prev_vld = bus.M_VALID;
      prev_pop = bus.M_VALID && bus.M_READY;
      prev_dat = bus.M_DATA;
    end else begin
      prev_vld = 1'b0;
      prev_pop = 1'b0;
    end
  end

  task automatic wr(input logic [W-1:0] d);
    fq.push_back(d);
    sb.push_back(d);
  endtask

  task automatic tick();
    @(posedge RCLK);
    #2;
  endtask

  task automatic drain(input string nm, input int bound);
    for (int k = 0; k < bound && sb.size() != 0; k++) tick();
    chk(nm, 32'(sb.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    int   cnt;
    int   base;
    int   got;
    int   written;

    // Streaming 23,25,ff,13 from reset release: REN at cycle 0, first M_VALID at cycle 2.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h23, 2'd1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h25, 2'd1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'hff, 2'd1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h13, 2'd1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

    tick();
    chk("rst_ren", 32'(bus.REN), 0);
    chk("rst_vld", 32'(bus.M_VALID), 0);
    chk("rst_occ", 32'(bus.OCC), 0);
    chk("rst_dat", 32'(bus.M_DATA), 0);
    wr(8'h23); wr(8'h25); wr(8'hff); wr(8'h13);
    tick();
    chk("rst_ren_nonempty", 32'(bus.REN), 0);
    rdy = tbl[0].rdy;
    RRST = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rdy = tbl[i].rdy;
      @(negedge RCLK);
      chk($sformatf("tbl%0d_ren", i), 32'(bus.REN), 32'(tbl[i].ren));
      chk($sformatf("tbl%0d_vld", i), 32'(bus.M_VALID), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_occ", i), 32'(bus.OCC), 32'(tbl[i].occ));
      if (tbl[i].vld) chk($sformatf("tbl%0d_dat", i), 32'(bus.M_DATA), 32'(tbl[i].dat));
      tick();
    end
    chk("stream_drained", 32'(sb.size()), 0);

    // Underflow: a lone word, then the FIFO stays empty.
    base = n_deliv;
    cnt = 0;
    wr(8'h10);
    repeat (8) begin
      @(negedge RCLK);
      if (bus.REN) cnt++;
    end
    chk("uf_ren_pulses", 32'(cnt), 1);
    chk("uf_delivered", 32'(n_deliv - base), 1);
    chk("uf_vld_low", 32'(bus.M_VALID), 0);

    // Backpressure: 16 words with M_READY low, then release.
    tick();
    rdy = 1'b0;
    base = n_deliv;
    cnt = 0;
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
    repeat (12) begin
      @(negedge RCLK);
      if (bus.REN) cnt++;
    end
    chk("bp_ren_pulses", 32'(cnt), 2);
    chk("bp_occ", 32'(bus.OCC), 2);
    chk("bp_head", 32'(bus.M_DATA), 32'h40);
    tick();
    rdy = 1'b1;
    drain("bp_drain", 64);
    chk("bp_delivered", 32'(n_deliv - base), 16);

    // Reset with a full buffer: buffered words are lost, next delivered is the next FIFO word.
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) wr(8'(8'hA0 + i));
    repeat (8) @(negedge RCLK);
    chk("pre_rst_occ", 32'(bus.OCC), 2);
    @(posedge RCLK);
    #3;
    RRST = 1'b1;
    #1;
    chk("arst_ren", 32'(bus.REN), 0);
    chk("arst_vld", 32'(bus.M_VALID), 0);
    chk("arst_occ", 32'(bus.OCC), 0);
    chk("arst_dat", 32'(bus.M_DATA), 0);
    repeat (n_read - n_deliv) void'(sb.pop_front());
    n_read = n_deliv;
    @(posedge RCLK);
    tick();
    RRST = 1'b0;
    rdy = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(negedge RCLK);
      if (bus.M_VALID) begin
        got = 1;
        chk("rst_next_word", 32'(bus.M_DATA), 32'hA2);
      end
    end
    chk("rst_valid_seen", 32'(got), 1);
    tick();
    drain("rst_drain", 64);

    // Random stress: sparse writes, random M_READY.
    base = n_deliv;
    written = 0;
    for (int cyc = 0; cyc < 20000 && written < 1000; cyc++) begin
      tick();
      rdy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        wr(8'($urandom));
        written++;
      end
    end
    chk("rnd_written", 32'(written), 1000);
    tick();
    rdy = 1'b1;
    drain("rnd_drain", 2000);
    chk("rnd_delivered", 32'(n_deliv - base), 1000);
    tick();
    tick();
    chk("end_vld_low", 32'(bus.M_VALID), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
